// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared piece codes, LFSR tap masks and bag helper
// Purpose : constants and helper functions shared by the piece randomizer.
// Ports   : none (package).
package tetris_pkg;

   localparam int NUM_PIECES = 7;

   localparam logic [2:0] PIECE_I = 3'd0;
   localparam logic [2:0] PIECE_O = 3'd1;
   localparam logic [2:0] PIECE_T = 3'd2;
   localparam logic [2:0] PIECE_S = 3'd3;
   localparam logic [2:0] PIECE_Z = 3'd4;
   localparam logic [2:0] PIECE_J = 3'd5;
   localparam logic [2:0] PIECE_L = 3'd6;

   // Maximal-length masks for a right-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         8:       lfsr_taps = 32'h0000_00B8;
         32:      lfsr_taps = 32'h8020_0003;
         default: lfsr_taps = 32'h0000_B400;
      endcase
   endfunction

   // Lowest-numbered piece whose bag bit is clear; 0 if the bag is full.
   function automatic logic [2:0] lowest_unused(input logic [6:0] bag);
      lowest_unused = 3'd0;
      for (int i = NUM_PIECES - 1; i >= 0; i--) begin
         if (!bag[i]) lowest_unused = i[2:0];
      end
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - Galois LFSR with synchronous load and clock enable
// Purpose : pseudo-random source; shifts right each enabled cycle.
// Ports   : clk      - clock
//           reset    - asynchronous active-high reset (state <- SEED)
//           ce       - clock enable; state holds when low
//           load     - load load_val (zero is replaced by 1)
//           load_val - runtime seed
//           state    - current LFSR state
module lfsr_galois #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] SEED  = 1,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state
);

   // The all-zero state is a lock-up point, so it is never loaded.
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? ONE : SEED;

   logic [WIDTH-1:0] r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= SEED_NZ;
      end else if (ce) begin
         if (load)
            r_state <= (load_val == '0) ? ONE : load_val;
         else
            r_state <= {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);
      end
   end

   assign state = r_state;

endmodule

// File: rtl/piece_randomizer.sv
// rtl/piece_randomizer.sv - piece generator with preview queue and 7-bag
// Purpose : draws piece codes 0..6 from an LFSR into a head+preview queue.
// Ports   : clk, reset (async, active-high), ce (clock enable)
//           block_new     - consume head piece (held pending if queue empty)
//           seed_load     - load seed_in into LFSR, flush queue/bag/retry
//           seed_in       - runtime seed
//           piece_out     - head piece, piece_valid - head occupied
//           preview       - next pieces, entry k at [3k+2:3k]
//           preview_count - number of valid preview entries
module piece_randomizer
   import tetris_pkg::*;
#(
   parameter int          LFSR_W      = 16,
   parameter logic [31:0] SEED        = 32'h0001,
   parameter int          QUEUE_DEPTH = 3,
   parameter int          BAG_MODE    = 1,
   parameter int          MAX_RETRY   = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ce,
   input  logic                       block_new,
   input  logic                       seed_load,
   input  logic [LFSR_W-1:0]          seed_in,
   output logic [2:0]                 piece_out,
   output logic                       piece_valid,
   output logic [3*QUEUE_DEPTH-1:0]   preview,
   output logic [2:0]                 preview_count
);

   localparam int                SLOTS    = QUEUE_DEPTH + 1;
   localparam logic [31:0]       TAPS32   = lfsr_taps(LFSR_W);
   localparam logic [LFSR_W-1:0] TAPS     = TAPS32[LFSR_W-1:0];
   localparam logic [LFSR_W-1:0] SEED_W   = SEED[LFSR_W-1:0];
   localparam logic [7:0]        RETRY_MX = MAX_RETRY[7:0];
   localparam logic [2:0]        SLOTS_B  = SLOTS[2:0];

   logic [LFSR_W-1:0] w_lfsr;
   logic              w_unused_lfsr;

   logic [2:0] r_slot [SLOTS];
   logic [2:0] r_occ;
   logic [6:0] r_bag;
   logic [7:0] r_retry;
   logic       r_pending;

   logic [2:0] w_slot_nxt [SLOTS];
   logic [2:0] w_occ_nxt;
   logic [2:0] w_occ_after;
   logic [6:0] w_bag_nxt;
   logic [6:0] w_eff_bag;
   logic [7:0] w_bag8;
   logic [7:0] w_retry_nxt;
   logic       w_pending_nxt;
   logic [2:0] w_cand;
   logic [2:0] w_fb_piece;
   logic [2:0] w_piece;
   logic       w_valid;
   logic       w_full;
   logic       w_pop;
   logic       w_draw;
   logic       w_fallback;
   logic       w_cand_ok;
   logic       w_accept;

   lfsr_galois #(
      .WIDTH (LFSR_W),
      .SEED  (SEED_W),
      .TAPS  (TAPS)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .load     (seed_load),
      .load_val (seed_in),
      .state    (w_lfsr)
   );

   // Only the low three bits feed the draw.
   assign w_unused_lfsr = ^w_lfsr;

   always_comb begin
      w_valid    = (r_occ != 3'd0);
      w_full     = (r_occ == SLOTS_B);
      w_pop      = (block_new | r_pending) & w_valid;
      w_draw     = !w_full;
      w_cand     = w_lfsr[2:0];
      // A full bag is treated as already cleared so this edge can draw.
      w_eff_bag  = (r_bag == 7'h7F) ? 7'h00 : r_bag;
      // Bit 7 stands in for the never-valid code 7.
      w_bag8     = (BAG_MODE != 0) ? {1'b1, w_eff_bag} : 8'h80;
      w_cand_ok  = !w_bag8[w_cand];
      w_fallback = (r_retry == RETRY_MX);
      if (BAG_MODE != 0)
         w_fb_piece = lowest_unused(w_eff_bag);
      else
         w_fb_piece = (w_cand == 3'd7) ? 3'd0 : w_cand;
      w_piece    = w_fallback ? w_fb_piece : w_cand;
      w_accept   = w_draw & (w_fallback | w_cand_ok);

      // Shift on pop, then drop the accepted piece into the lowest free slot.
      w_occ_after = r_occ - {2'b00, w_pop};
      for (int i = 0; i < SLOTS - 1; i++) begin
         w_slot_nxt[i] = w_pop ? r_slot[i+1] : r_slot[i];
      end
      w_slot_nxt[SLOTS-1] = w_pop ? 3'd0 : r_slot[SLOTS-1];
      for (int i = 0; i < SLOTS; i++) begin
         if (w_accept && (w_occ_after == i[2:0])) w_slot_nxt[i] = w_piece;
      end
      w_occ_nxt = w_occ_after + {2'b00, w_accept};

      if (BAG_MODE != 0)
         w_bag_nxt = w_eff_bag | (w_accept ? (7'b1 << w_piece) : 7'b0);
      else
         w_bag_nxt = 7'h00;

      if (w_accept)
         w_retry_nxt = 8'd0;
      else if (w_draw)
         w_retry_nxt = r_retry + 8'd1;
      else
         w_retry_nxt = r_retry;

      if (w_pop)
         w_pending_nxt = 1'b0;
      else if (block_new && !w_valid)
         w_pending_nxt = 1'b1;
      else
         w_pending_nxt = r_pending;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) r_slot[i] <= 3'd0;
         r_occ     <= 3'd0;
         r_bag     <= 7'h00;
         r_retry   <= 8'd0;
         r_pending <= 1'b0;
      end else if (ce) begin
         if (seed_load) begin
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= 3'd0;
            r_occ     <= 3'd0;
            r_bag     <= 7'h00;
            r_retry   <= 8'd0;
            r_pending <= 1'b0;
         end else begin
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= w_slot_nxt[i];
            r_occ     <= w_occ_nxt;
            r_bag     <= w_bag_nxt;
            r_retry   <= w_retry_nxt;
            r_pending <= w_pending_nxt;
         end
      end
   end

   assign piece_out     = r_slot[0];
   assign piece_valid   = (r_occ != 3'd0);
   assign preview_count = (r_occ == 3'd0) ? 3'd0 : (r_occ - 3'd1);

   always_comb begin
      preview = '0;
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
         preview[3*k +: 3] = r_slot[k+1];
      end
   end

endmodule

// File: tb/tb_piece_randomizer.sv
// tb/tb_piece_randomizer.sv - directed self-checking bench for piece_randomizer
module tb_piece_randomizer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        block_new;
   logic        seed_load;
   logic [15:0] seed_in;
   logic [2:0]  piece_out;
   logic        piece_valid;
   logic [8:0]  preview;
   logic [2:0]  preview_count;

   logic        fb_block_new;
   logic        fb_seed_load;
   logic [2:0]  fb_piece_out;
   logic        fb_piece_valid;
   logic [8:0]  fb_preview;
   logic [2:0]  fb_preview_count;

   int checks   = 0;
   int failures = 0;

   logic [2:0]  popped [$];
   logic [2:0]  seq_a  [$];
   logic [2:0]  hold_out;
   logic [8:0]  hold_prev;
   logic [15:0] hold_lfsr;

   always #5 clk = ~clk;

   piece_randomizer u_dut (
      .clk           (clk),
      .reset         (reset),
      .ce            (ce),
      .block_new     (block_new),
      .seed_load     (seed_load),
      .seed_in       (seed_in),
      .piece_out     (piece_out),
      .piece_valid   (piece_valid),
      .preview       (preview),
      .preview_count (preview_count)
   );

   piece_randomizer #(.MAX_RETRY(0), .BAG_MODE(1)) u_fb (
      .clk           (clk),
      .reset         (reset),
      .ce            (ce),
      .block_new     (fb_block_new),
      .seed_load     (fb_seed_load),
      .seed_in       (seed_in),
      .piece_out     (fb_piece_out),
      .piece_valid   (fb_piece_valid),
      .preview       (fb_preview),
      .preview_count (fb_preview_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed_in   = s;
      seed_load = 1'b1;
      tick(1);
      seed_load = 1'b0;
   endtask

   task automatic collect(input int n);
      int w;
      for (int p = 0; p < n; p++) begin
         w = 0;
         while (!piece_valid && w < 200) begin
            tick(1);
            w++;
         end
         if (!piece_valid) begin
            check("pop_wait_timeout", 32'(piece_valid), 32'd1);
            return;
         end
         popped.push_back(piece_out);
         block_new = 1'b1;
         tick(1);
         block_new = 1'b0;
      end
   endtask

   initial begin
      logic [6:0] m;
      int         w;
      reset        = 1'b1;
      ce           = 1'b0;
      block_new    = 1'b0;
      seed_load    = 1'b0;
      seed_in      = 16'h0000;
      fb_block_new = 1'b0;
      fb_seed_load = 1'b0;

      tick(2);
      check("rst_valid",   32'(piece_valid),   32'd0);
      check("rst_out",     32'(piece_out),     32'd0);
      check("rst_preview", 32'(preview),       32'd0);
      check("rst_count",   32'(preview_count), 32'd0);

      // Fill from seed 1: draws 1, 0, then seven rejected 0s, then 4, 2.
      ce = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      check("fill1_valid", 32'(piece_valid),   32'd1);
      check("fill1_out",   32'(piece_out),     32'd1);
      check("fill1_count", 32'(preview_count), 32'd0);
      tick(2);
      check("fill3_count", 32'(preview_count), 32'd1);

      // Reset mid-fill takes effect without a clock edge.
      #1 reset = 1'b1;
      #1;
      check("midrst_valid",   32'(piece_valid), 32'd0);
      check("midrst_out",     32'(piece_out),   32'd0);
      check("midrst_preview", 32'(preview),     32'd0);
      tick(1);
      reset = 1'b0;
      tick(11);
      check("full_valid",   32'(piece_valid),   32'd1);
      check("full_out",     32'(piece_out),     32'd1);
      check("full_preview", 32'(preview),       32'o240);
      check("full_count",   32'(preview_count), 32'd3);
      check("fb_full_out",     32'(fb_piece_out), 32'd0);
      check("fb_full_preview", 32'(fb_preview),   32'o321);

      // Pop on a full queue: no draw that edge, refill with 6 on the next.
      block_new = 1'b1;
      tick(1);
      block_new = 1'b0;
      check("pop_out",     32'(piece_out),     32'd0);
      check("pop_count",   32'(preview_count), 32'd2);
      check("pop_preview", 32'(preview),       32'o024);
      tick(1);
      check("refill_preview", 32'(preview),       32'o624);
      check("refill_count",   32'(preview_count), 32'd3);

      // Fallback with MAX_RETRY=0: after bag {0..5}, next piece is 6.
      for (int i = 0; i < 3; i++) begin
         fb_block_new = 1'b1;
         tick(1);
         fb_block_new = 1'b0;
         tick(1);
      end
      check("fb_out",     32'(fb_piece_out),  32'd3);
      check("fb_preview", 32'(fb_preview),    32'o654);
      check("fb_bag_all", 32'(u_fb.r_bag),    32'h7F);
      tick(1);
      check("fb_bag_clr", 32'(u_fb.r_bag),    32'h00);

      // Zero seed is replaced by 1 and the queue is flushed.
      load_seed(16'h0000);
      check("seed0_lfsr",  32'(u_dut.u_lfsr.state), 32'd1);
      check("seed0_valid", 32'(piece_valid),        32'd0);
      check("seed0_count", 32'(preview_count),      32'd0);

      // Early request: ACE1 draws 1, 0, then rejects 0.
      load_seed(16'hACE1);
      tick(3);
      check("noreq_count", 32'(preview_count), 32'd1);
      check("noreq_out",   32'(piece_out),     32'd1);
      load_seed(16'hACE1);
      block_new = 1'b1;
      tick(1);
      block_new = 1'b0;
      check("req_pending_set", 32'(u_dut.r_pending), 32'd1);
      check("req_valid",       32'(piece_valid),     32'd1);
      tick(2);
      check("req_pending_clr", 32'(u_dut.r_pending), 32'd0);
      check("req_count",       32'(preview_count),   32'd0);
      check("req_out",         32'(piece_out),       32'd0);

      // Same seed twice gives the same piece sequence.
      popped.delete();
      load_seed(16'hACE1);
      collect(8);
      seq_a = popped;
      popped.delete();
      load_seed(16'hACE1);
      collect(8);
      check("seed_first_piece", 32'(seq_a[0]), 32'd1);
      for (int i = 0; i < 8; i++) check("seed_repeat", 32'(popped[i]), 32'(seq_a[i]));

      // Bag: every aligned group of seven pops is a permutation.
      popped.delete();
      load_seed(16'h1234);
      collect(70);
      for (int g = 0; g < 10; g++) begin
         m = 7'h00;
         for (int j = 0; j < 7; j++) m = m | (7'b1 << popped[g*7+j]);
         check("bag_perm", 32'(m), 32'h7F);
      end

      // Clock enable: nothing moves and block_new is not remembered.
      w = 0;
      while (preview_count != 3'd3 && w < 100) begin
         tick(1);
         w++;
      end
      check("ce_prefill", 32'(preview_count), 32'd3);
      hold_out  = piece_out;
      hold_prev = preview;
      hold_lfsr = u_dut.u_lfsr.state;
      ce = 1'b0;
      for (int i = 0; i < 10; i++) begin
         block_new = ~block_new;
         tick(1);
      end
      block_new = 1'b0;
      check("ce_out",     32'(piece_out),            32'(hold_out));
      check("ce_preview", 32'(preview),              32'(hold_prev));
      check("ce_lfsr",    32'(u_dut.u_lfsr.state),   32'(hold_lfsr));
      check("ce_pending", 32'(u_dut.r_pending),      32'd0);
      ce = 1'b1;
      tick(1);
      check("ce_nopop_out",     32'(piece_out), 32'(hold_out));
      check("ce_nopop_preview", 32'(preview),   32'(hold_prev));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piece_randomizer.md
PIECE_RANDOMIZER -- requirements
Module: piece_randomizer

Interface
REQ-001 Parameter LFSR_W, default 16: LFSR width; 8, 16 or 32 only.
REQ-002 Parameter SEED, default 16'h0001: reset value of the LFSR, truncated to LFSR_W.
REQ-003 Parameter QUEUE_DEPTH, default 3: number of preview entries behind the head, range 1..6.
REQ-004 Parameter BAG_MODE, default 1: 0 selects uniform rejection sampling; 1 selects the 7-bag mode.
REQ-005 Parameter MAX_RETRY, default 15: number of rejected draws before the fallback applies, range 0..255.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ce  in  1  clock enable; when 0, all state holds.
REQ-009 block_new  in  1  single-cycle request to consume the head piece.
REQ-010 seed_load  in  1  loads seed_in and flushes the queue.
REQ-011 seed_in  in  LFSR_W  runtime seed value.
REQ-012 piece_out  out  3  head piece code, 0..6.
REQ-013 piece_valid  out  1  piece_out holds a valid piece.
REQ-014 preview  out  3*QUEUE_DEPTH  preview entries; entry k occupies bits [3k+2:3k], where k=0 is the next piece.
REQ-015 preview_count  out  3  number of valid preview entries.

Function
REQ-016 The LFSR shall be a maximal-length Galois LFSR using the tap mask from the package, and shall advance every cycle that ce=1.
REQ-017 Candidate = LFSR[2:0]. A value of 7 is rejected. In BAG_MODE=1, a candidate whose bag bit is set is also rejected.
REQ-018 At most one candidate is evaluated per cycle, and only when the queue (head plus previews, QUEUE_DEPTH+1 slots) is not full.
REQ-019 An accepted candidate shall be written to the lowest empty slot in the same cycle; in BAG_MODE=1 its bag bit is set in the same cycle.
REQ-020 Retry counter behaviour: increments on each rejection; clears on each acceptance. When it equals MAX_RETRY, the next draw skips the LFSR and takes a fallback piece: the lowest-numbered unused piece in BAG_MODE=1, or LFSR[2:0] mod 7 in BAG_MODE=0.
REQ-021 When all 7 bag bits are set, the bag shall clear on the next edge. That edge may accept a new candidate against the cleared bag.
REQ-022 Pop: block_new=1 with ce=1 and piece_valid=1 shifts the queue by one entry. From the next cycle, piece_out shows the former preview[0].
REQ-023 block_new while piece_valid=0 shall set a pending flag. The pop shall execute in the first cycle in which piece_valid=1, and the flag then clears.
REQ-024 Pop and accept in the same cycle: the queue shifts and the accepted entry is written to the freed position; occupancy is unchanged.
REQ-025 piece_valid shall be 1 exactly when the head slot is occupied. preview_count = occupancy-1, saturating at 0.
REQ-026 Empty slots shall read as 3'b000.
REQ-027 Precedence: seed_load has priority over all other inputs.
REQ-028 seed_load=1 with ce=1 shall load seed_in into the LFSR, substituting 1 if seed_in is 0, and shall clear the queue, bag, retry counter and pending flag.
REQ-029 When ce=0, block_new and seed_load are ignored and are not latched.
REQ-030 The all-zero LFSR state is unreachable.
REQ-031 From an empty queue with ce=1, the queue shall fill within (QUEUE_DEPTH+1)*(MAX_RETRY+1)+1 cycles.

Reset
REQ-032 Asserting reset shall immediately set: LFSR=SEED (1 if SEED is zero); queue, bag, retry counter and pending flag = 0; piece_out=0; piece_valid=0; preview=0; preview_count=0.
REQ-033 Filling shall start on the first edge after reset deasserts, provided ce=1.
REQ-034 Reset asserted in the middle of an operation shall discard any in-flight pop or fill.

Structure
REQ-035 The shared package tetris_pkg shall hold: the piece-code constants (I,O,T,S,Z,J,L = 0..6), NUM_PIECES=7, and the function lfsr_taps(width) returning the maximal-length masks 8'hB8, 16'hB400 and 32'h80200003.
REQ-036 The LFSR shall be a separate sub-module lfsr_galois, parametrised by width, seed and taps, with ports clk, reset, ce, load, load_val and state.
REQ-037 The queue, bag, retry counter and pending flag shall reside in piece_randomizer.

Verification
REQ-038 Reset test: assert reset mid-fill -> piece_valid=0, piece_out=0 and preview=0 immediately. Release reset with ce=1, defaults -> piece_valid=1 and preview_count=3 within 65 cycles.
REQ-039 Bag test: BAG_MODE=1, 70 pops -> each consecutive aligned group of 7 pieces is a permutation of 0..6.
REQ-040 Seed test: seed_load with seed_in=0 -> LFSR state=1, then piece_valid=0 on the next cycle. Repeating with seed_in=16'hACE1 twice -> identical piece sequences.
REQ-041 Early request test: block_new while the queue is empty -> the pending flag is set. The pop occurs on the first valid cycle, and afterwards preview_count is one lower than without the request.
REQ-042 Fallback test: MAX_RETRY=0, BAG_MODE=1, bag={0,1,2,3,4,5} set -> the next accepted piece is 6, and then the bag clears.
REQ-043 Enable test: ce=0 with block_new pulses for 10 cycles -> piece_out, preview and LFSR unchanged, and no pop after ce returns to 1.
